// File: rtl/mod_i2s_tx.sv
// rtl/mod_i2s_tx.sv - I2S transmitter with sample FIFO and per-frame sample request
module mod_i2s_tx #(
   parameter int CLK_DIV      = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int SAMPLE_WIDTH = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [SAMPLE_WIDTH-1:0]       i_sample,
   input  logic                          i_sample_valid,
   output logic                          o_sample_req,
   output logic                          o_bclk,
   output logic                          o_lrclk,
   output logic                          o_sdata,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow,
   output logic                          o_underflow
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   // bit clock divider
   logic [DIV_W-1:0]        r_div;
   logic                    r_bclk;

   // frame sequencing and serial outputs
   logic [5:0]              r_f;
   logic [SAMPLE_WIDTH-1:0] r_frame;
   logic                    r_lrclk;
   logic                    r_sdata;
   logic                    r_sample_req;
   logic                    r_underflow;

   // sample FIFO
   logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [LVL_W-1:0]        r_level;
   logic                    r_overflow;

   logic                    w_tick;
   logic                    w_fall;
   logic [5:0]              w_f_next;
   logic                    w_frame_start;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;
   logic [SAMPLE_WIDTH-1:0] w_frame_next;
   logic [4:0]              w_bit_idx;
   logic                    w_lr_next;

   // A fall event is the divider wrap while bclk is high; all serial outputs
   // move only here so the DAC sees stable data on the rising edge.
   assign w_tick        = (r_div == DIV_LAST);
   assign w_fall        = w_tick & r_bclk;
   assign w_f_next      = r_f + 6'd1;
   assign w_frame_start = w_fall & (w_f_next == 6'd0);

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == LVL_FULL);

   // Pop only when something is already stored: a push in the same cycle
   // never falls through to an empty FIFO's output.
   assign w_pop  = w_frame_start & ~w_empty;
   // A full FIFO still accepts a push when the same cycle pops a slot free.
   assign w_push = i_sample_valid & (~w_full | w_pop);
   assign w_drop = i_sample_valid & w_full & ~w_pop;

   assign w_frame_next = w_frame_start ? (w_empty ? '0 : r_mem[r_rd_ptr]) : r_frame;
   // 31-f for the left slot and 63-f for the right slot share the low five bits.
   assign w_bit_idx    = ~w_f_next[4:0];
   assign w_lr_next    = (w_f_next >= 6'd31) && (w_f_next <= 6'd62);

   // Divider: wrap at CLK_DIV-1 and toggle the bit clock
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_tick) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + DIV_W'(1);
      end
   end

   // Frame counter, frame register, word select, serial data and frame pulses
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_f          <= 6'd63;
         r_frame      <= '0;
         r_lrclk      <= 1'b0;
         r_sdata      <= 1'b0;
         r_sample_req <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_sample_req <= w_frame_start;
         r_underflow  <= w_frame_start & w_empty;
         if (w_fall) begin
            r_f     <= w_f_next;
            r_frame <= w_frame_next;
            r_lrclk <= w_lr_next;
            r_sdata <= w_frame_next[w_bit_idx];
         end
      end
   end

   // Sample FIFO storage, pointers, level and overflow pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_drop;
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_sample;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
   end

   assign o_bclk       = r_bclk;
   assign o_lrclk      = r_lrclk;
   assign o_sdata      = r_sdata;
   assign o_sample_req = r_sample_req;
   assign o_underflow  = r_underflow;
   assign o_overflow   = r_overflow;
   assign o_fifo_level = r_level;

endmodule

// File: doc/mod_i2s_tx.md
Name: mod_i2s_tx

Overview:
- Serial audio transmitter at the sink end of the synth sample stream.
- Accepts 32-bit signed samples with a one-cycle valid strobe and buffers them in a small FIFO.
- Serialises each sample as an I2S frame (the same mono sample on left and right) to an external DAC.
- Issues one sample-request pulse per frame; the request drives the synth's trigger input, so the synth runs at the DAC frame rate.

Parameters:
- CLK_DIV, 4, i_clk cycles per half-period of o_bclk (>=1); bclk = f_clk/(2*CLK_DIV).
- FIFO_DEPTH, 4, sample FIFO entries (power of two, >=2).
- SAMPLE_WIDTH, 32, bits per channel slot; fixed at 32 for this release.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_sample  in  32  signed sample, two's complement
- i_sample_valid  in  1  one-cycle strobe; push i_sample
- o_sample_req  out  1  one-cycle pulse at each frame start; connect to synth trigger
- o_bclk  out  1  I2S bit clock
- o_lrclk  out  1  I2S word select; 0 = left, 1 = right
- o_sdata  out  1  I2S serial data, MSB first
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_overflow  out  1  one-cycle pulse: push dropped (FIFO full)
- o_underflow  out  1  one-cycle pulse: frame start with FIFO empty

Behaviour:
- Reset (async on i_rst high, all registers):
  - o_bclk=0, o_lrclk=0, o_sdata=0, o_sample_req=0, o_overflow=0, o_underflow=0.
  - FIFO empty (level 0), divider=0, frame counter f=63, shift register=0.
- Divider:
  - Counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and toggles o_bclk.
  - A 1->0 toggle is a "fall event". Outputs change only on fall events, so the DAC samples on the rising edge.
- Frame counter f (0..63, mod-64 wrap):
  - Advances on each fall event.
  - All statements below use the new value of f.
- Word select: o_lrclk=1 when f is in 31..62, else 0. It transitions one bclk before each channel MSB (standard I2S).
- Frame start (fall event with f=0):
  - FIFO non-empty: pop the head into the frame register.
  - FIFO empty: frame register=0 (silence) and o_underflow pulses.
  - o_sample_req pulses for one i_clk cycle in both cases.
- Data:
  - f in 0..31: o_sdata = frame bit 31-f.
  - f in 32..63: o_sdata = frame bit 63-f (right channel repeats left).
  - The frame register is held for the whole frame.
- Push:
  - i_sample_valid with FIFO not full: write i_sample and increment level.
  - i_sample_valid with FIFO full and no pop that cycle: drop the sample, o_overflow pulses, contents unchanged.
- Simultaneous push and pop in one cycle:
  - Both succeed; level unchanged.
  - Allowed when full (the pop frees the slot).
  - When empty, no fall-through: the pop sees empty (underflow, silence) and the push is stored.
- Timing:
  - First fall event occurs 2*CLK_DIV cycles after reset release.
  - Frame period = 128*CLK_DIV i_clk cycles.
  - o_sample_req to next pop = one frame period. The synth therefore has a full frame to deliver a sample.
- i_sample_valid during reset is ignored.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously), and the FIFO is flushed.

Test Plan:
1. Hold i_rst=1 mid-stream with a non-empty FIFO -> o_bclk, o_lrclk, o_sdata, o_sample_req, flags and o_fifo_level all 0 without waiting for a clock edge. After release, first o_bclk rise at cycle CLK_DIV and first fall at cycle 2*CLK_DIV.
2. CLK_DIV=2: push 0x8000_0001 before the first frame -> o_sdata per bclk is 1, 30x0, 1, then the same for the right slot. o_lrclk rises at f=31 and falls at f=63. o_sample_req pulses exactly every 256 cycles.
3. No pushes -> o_sdata stuck at 0 and o_underflow pulses with each o_sample_req. Then one push of 0x7FFF_FFFF -> the next frame carries 0 then 31x1 per slot, and underflow stops.
4. DEPTH=4: five back-to-back pushes away from a frame start -> level 4 and o_overflow pulses once on the fifth push. The frames that follow play samples 1-4 in order; sample 5 is never heard.
5. FIFO full with i_sample_valid on the exact frame-start cycle -> no overflow, level stays 4, and the new sample plays last.
6. FIFO empty with push on the frame-start cycle -> underflow pulse and silent frame, level 1 afterwards, and the pushed sample plays in the next frame.
